// File: rtl/fetch_redirect_unit_pkg.sv
// rtl/fetch_redirect_unit_pkg.sv - shared widths, FSM encoding and buffer entry type for instruction fetch
package fetch_redirect_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - branch, instruction memory and decode signals of the fetch stage
interface fetch_redirect_unit_if;
    import fetch_redirect_unit_pkg::*;

    logic               j_accept;
    logic               j_wait;
    logic [XLEN-1:0]    j_addr;
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [XLEN-1:0]    dec_pc;
    logic               misalign;

    modport master (
        input  j_accept, j_wait, j_addr, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, misalign
    );

    modport slave (
        output j_accept, j_wait, j_addr, imem_gnt, imem_rvalid, imem_rdata, dec_ready,
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, misalign
    );

endinterface

// File: rtl/fetch_redirect_unit_fetch_buffer.sv
// rtl/fetch_redirect_unit_fetch_buffer.sv - synchronous FIFO of fetched {pc, instr} pairs with flush
module fetch_buffer
    import fetch_redirect_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - sequential fetch with redirect, stall and kill of in-flight responses
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_redirect_unit_if.master bus_io
);

    localparam int unsigned AW   = $clog2(BUF_DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(BUF_DEPTH - 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            misalign_q, misalign_d;

    logic            handshake;
    logic            push;
    logic            pop;
    logic            space;
    logic            req_slot;
    logic            buf_full;
    logic            buf_empty;
    logic [AW:0]     buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    buf_in;

    assign handshake = bus_io.imem_req & bus_io.imem_gnt;
    assign push      = (state_q == WAIT) & bus_io.imem_rvalid & ~bus_io.j_accept;
    assign pop       = bus_io.dec_valid & bus_io.dec_ready & ~bus_io.j_accept;

    // Occupancy after this cycle's push/pop must leave room for the response of a new request.
    assign space = pop  ? (~push | ~buf_full)
                 : push ? (buf_count < LAST)
                 :        ~buf_full;

    assign req_slot         = (state_q == IDLE) | ((state_q == WAIT) & bus_io.imem_rvalid);
    assign bus_io.imem_req  = ~rst & req_slot & ~bus_io.j_wait & ~bus_io.j_accept & space;
    assign bus_io.imem_addr = pc_q;
    assign bus_io.dec_valid = ~buf_empty & ~bus_io.j_wait;
    assign bus_io.dec_pc    = buf_head.pc;
    assign bus_io.dec_instr = buf_head.instr;
    assign bus_io.misalign  = misalign_q;

    assign buf_in = '{pc: req_pc_q, instr: bus_io.imem_rdata};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        misalign_d = bus_io.j_accept & (bus_io.j_addr[1:0] != 2'b00);

        if (handshake) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
        if (bus_io.j_accept) begin
            pc_d = {bus_io.j_addr[XLEN-1:2], 2'b00};
        end

        unique case (state_q)
            IDLE: if (handshake) state_d = WAIT;
            WAIT: begin
                if (bus_io.j_accept) begin
                    state_d = bus_io.imem_rvalid ? IDLE : KILL;
                end else if (bus_io.imem_rvalid) begin
                    state_d = handshake ? WAIT : IDLE;
                end
            end
            KILL: if (bus_io.imem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus_io.j_accept),
        .data_i  (buf_in),
        .head_o  (buf_head),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed vector bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_redirect_unit_if bus ();

    fetch_redirect_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        bit          ja;
        bit          jw;
        logic [31:0] jaddr;
        bit          rdy;
        bit          gnt;
        int          lat;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_dv;
        logic [31:0] e_pc;
        bit          e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Memory responder: one outstanding request, rdata = ~address, latency rsp_lat cycles.
    int          rsp_lat = 1;
    bit          rsp_pend = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;
    logic        rsp_hs;
    logic [31:0] rsp_a;

    always @(posedge clk) begin
        rsp_hs = bus.imem_req && bus.imem_gnt;
        rsp_a  = bus.imem_addr;
        #1;
        bus.imem_rvalid = 1'b0;
        if (rsp_hs) begin
            rsp_pend = 1;
            rsp_cnt  = rsp_lat;
            rsp_addr = rsp_a;
        end
        if (rsp_pend) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ~rsp_addr;
                rsp_pend        = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic row(input bit rb, input bit ja, input bit jw, input logic [31:0] jaddr,
                       input bit rdy, input bit gnt, input int lat,
                       input bit e_req, input logic [31:0] e_addr, input bit e_dv,
                       input logic [31:0] e_pc, input bit e_mis);
        vec_t v;
        v = '{rb, ja, jw, jaddr, rdy, gnt, lat, e_req, e_addr, e_dv, e_pc, e_mis};
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.j_accept  = 1'b0;
        bus.j_wait    = 1'b0;
        bus.j_addr    = '0;
        bus.dec_ready = 1'b0;
        bus.imem_gnt  = 1'b1;
    endtask

    task automatic apply_reset(input int idx);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        rsp_lat = 1;
        #1;
        chk("rst_req",   idx, 32'(bus.imem_req),  32'd0);
        chk("rst_dv",    idx, 32'(bus.dec_valid), 32'd0);
        chk("rst_mis",   idx, 32'(bus.misalign),  32'd0);
        chk("rst_pc",    idx, bus.dec_pc,         32'd0);
        chk("rst_instr", idx, bus.dec_instr,      32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive_idle();
        // A: streaming with decode always ready
        row(1,0,0,0,1,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h4,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h8,1,32'h0,0);
        row(0,0,0,0,1,1,1, 1,32'hC,1,32'h4,0);
        row(0,0,0,0,1,1,1, 1,32'h10,1,32'h8,0);
        // B: decode backpressure fills both entries, then resumes at 0x8
        row(1,0,0,0,0,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,0,1,1, 1,32'h4,0,0,0);
        row(0,0,0,0,0,1,1, 0,32'h8,1,32'h0,0);
        row(0,0,0,0,0,1,1, 0,32'h8,1,32'h0,0);
        row(0,0,0,0,0,1,1, 0,32'h8,1,32'h0,0);
        row(0,0,0,0,1,1,1, 1,32'h8,1,32'h0,0);
        row(0,0,0,0,1,1,1, 1,32'hC,1,32'h4,0);
        row(0,0,0,0,1,1,1, 1,32'h10,1,32'h8,0);
        // C: redirect to 0x100 while 0x8 is in flight; its response is killed
        row(1,0,0,0,1,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h4,0,0,0);
        row(0,0,0,0,1,1,3, 1,32'h8,1,32'h0,0);
        row(0,1,0,32'h100,1,1,1, 0,32'hC,1,32'h4,0);
        row(0,0,0,0,1,1,1, 0,32'h100,0,0,0);
        row(0,0,0,0,1,1,1, 0,32'h100,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h100,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h104,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h108,1,32'h100,0);
        // D: stall with one entry buffered
        row(1,0,0,0,1,1,1, 1,32'h0,0,0,0);
        row(0,0,1,0,1,1,1, 0,32'h4,0,0,0);
        row(0,0,1,0,1,1,1, 0,32'h4,0,0,0);
        row(0,0,1,0,1,1,1, 0,32'h4,0,0,0);
        row(0,0,1,0,1,1,1, 0,32'h4,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h4,1,32'h0,0);
        // E: misaligned target 0x203
        row(1,1,0,32'h203,1,1,1, 0,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h200,0,0,1);
        row(0,0,0,0,1,1,1, 1,32'h204,0,0,0);
        // F: redirect and stall together flush a full buffer
        row(1,0,0,0,0,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,0,1,1, 1,32'h4,0,0,0);
        row(0,0,0,0,0,1,1, 0,32'h8,1,32'h0,0);
        row(0,1,1,32'h40,0,1,1, 0,32'h8,0,0,0);
        row(0,0,1,0,0,1,1, 0,32'h40,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h40,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h44,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h48,1,32'h40,0);
        // H: request held with stable address until granted
        row(1,0,0,0,1,0,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,0,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h4,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h8,1,32'h0,0);
        // I: PC wraps from 0xFFFF_FFFC to 0
        row(1,1,0,32'hFFFF_FFFC,1,1,1, 0,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'hFFFF_FFFC,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h0,0,0,0);
        row(0,0,0,0,1,1,1, 1,32'h4,1,32'hFFFF_FFFC,0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) apply_reset(i);
            else @(negedge clk);
            bus.j_accept  = vecs[i].ja;
            bus.j_wait    = vecs[i].jw;
            bus.j_addr    = vecs[i].jaddr;
            bus.dec_ready = vecs[i].rdy;
            bus.imem_gnt  = vecs[i].gnt;
            rsp_lat       = vecs[i].lat;
            #1;
            chk("imem_req",  i, 32'(bus.imem_req),  32'(vecs[i].e_req));
            chk("imem_addr", i, bus.imem_addr,      vecs[i].e_addr);
            chk("dec_valid", i, 32'(bus.dec_valid), 32'(vecs[i].e_dv));
            chk("misalign",  i, 32'(bus.misalign),  32'(vecs[i].e_mis));
            if (vecs[i].e_dv) begin
                chk("dec_pc",    i, bus.dec_pc,    vecs[i].e_pc);
                chk("dec_instr", i, bus.dec_instr, ~vecs[i].e_pc);
            end
        end

        // G: reset while a request is outstanding; the late response must be ignored
        apply_reset(100);
        bus.dec_ready = 1'b1;
        rsp_lat = 2;
        #1;
        chk("g_req0", 100, 32'(bus.imem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("g_rst_req", 101, 32'(bus.imem_req),  32'd0);
        chk("g_rst_dv",  101, 32'(bus.dec_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_lat = 1;
        #1;
        chk("g_req1",  102, 32'(bus.imem_req),  32'd1);
        chk("g_addr1", 102, bus.imem_addr,      32'h0);
        chk("g_dv1",   102, 32'(bus.dec_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("g_dv2",   103, 32'(bus.dec_valid), 32'd0);
        chk("g_addr2", 103, bus.imem_addr,      32'h4);
        @(negedge clk);
        #1;
        chk("g_dv3",   104, 32'(bus.dec_valid), 32'd1);
        chk("g_pc3",   104, bus.dec_pc,         32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
